// File: rtl/axi4_line_fill_master.sv
// rtl/axi4_line_fill_master.sv - AXI4 read master turning one refill request into one INCR burst
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    refill request (any byte address inside the line)
//   resp_valid/resp_ready           assembled line handshake
//   resp_line                       beat k in bits [k*DATA_W +: DATA_W]
//   resp_err                        SLVERR/DECERR, wrong rid or bad rlast seen during the burst
//   arid..arready                   AXI4 AR channel (master side)
//   rid..rready                     AXI4 R channel (master side)
module axi4_line_fill_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int BEATS  = 4,
    parameter int ARID   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [BEATS*DATA_W-1:0] resp_line,
    output logic                    resp_err,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int CW    = $clog2(BEATS) + 1;
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_beat;
    logic          beat_err;

    assign req_ready = (state == S_IDLE);
    assign arid      = ID_W'(ARID);
    assign arlen     = 8'(BEATS - 1);
    assign arsize    = 3'($clog2(DATA_W / 8));
    assign arburst   = 2'b01;

    assign last_beat = (cnt == CW'(BEATS - 1));
    // rresp[1] set means SLVERR/DECERR; OKAY/EXOKAY pass.
    assign beat_err  = rresp[1] | (rid != ID_W'(ARID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_line  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        araddr    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        cnt       <= '0;
                        resp_err  <= 1'b0;
                        // Cleared here so slots skipped by an early rlast read as zero.
                        resp_line <= '0;
                        arvalid   <= 1'b1;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rvalid && rready) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (cnt == CW'(k)) begin
                                resp_line[k*DATA_W +: DATA_W] <= rdata;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (last_beat || rlast) begin
                            // Final beat must carry rlast; rlast before the final beat is always an error.
                            resp_err   <= resp_err | beat_err | (last_beat ? !rlast : 1'b1);
                            rready     <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            resp_err <= resp_err | beat_err;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    arvalid_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (arvalid && !arready) |=> arvalid);

endmodule
